// File: rtl/bus_arbiter_pkg.sv
// Shared bus definitions: target codes, requester indices and arbiter FSM states.
// Reused by the execution and memory blocks that sit on the address bus.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        OWNED,
        GAP
    } arbState_e;

    typedef enum logic [3:0] {
        TGT_INSTR = 4'd0,
        TGT_MEM   = 4'd1,
        TGT_ALU   = 4'd2,
        TGT_EXE   = 4'd3,
        TGT_REG   = 4'd4
    } target_e;

    localparam logic [1:0] REQ_EXE  = 2'd0;
    localparam logic [1:0] REQ_ALU  = 2'd1;
    localparam logic [1:0] REQ_HOST = 2'd2;

    function automatic logic [1:0] oneHotToIndex(input logic [2:0] oneHot);
        case (oneHot)
            3'b010:  return REQ_ALU;
            3'b100:  return REQ_HOST;
            default: return REQ_EXE;
        endcase
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Round-robin winner selection: search starts one past the last owner.
module rr_picker
    import bus_arbiter_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] pointer,
    output logic [2:0] winner
);

    always_comb begin
        winner = '0;
        case (pointer)
            REQ_EXE: begin
                if (req[REQ_ALU])       winner[REQ_ALU]  = 1'b1;
                else if (req[REQ_HOST]) winner[REQ_HOST] = 1'b1;
                else if (req[REQ_EXE])  winner[REQ_EXE]  = 1'b1;
            end
            REQ_ALU: begin
                if (req[REQ_HOST])      winner[REQ_HOST] = 1'b1;
                else if (req[REQ_EXE])  winner[REQ_EXE]  = 1'b1;
                else if (req[REQ_ALU])  winner[REQ_ALU]  = 1'b1;
            end
            default: begin
                if (req[REQ_EXE])       winner[REQ_EXE]  = 1'b1;
                else if (req[REQ_ALU])  winner[REQ_ALU]  = 1'b1;
                else if (req[REQ_HOST]) winner[REQ_HOST] = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/bus_arbiter.sv
// Three-way round-robin bus arbiter with hold timeout, a one-cycle release gap
// and target decode of the registered address bus.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned NUM_REQ        = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] done,
    input  logic [15:0]        addrIn0,
    input  logic [15:0]        addrIn1,
    input  logic [15:0]        addrIn2,
    output logic [NUM_REQ-1:0] grant,
    output logic [15:0]        addressBus,
    output logic               busValid,
    output logic [4:0]         targetEnable,
    output logic               decodeError,
    output logic               timeout
);

    localparam int unsigned HOLD_W = $clog2(TIMEOUT_CYCLES);

    arbState_e         state, stateNext;
    logic [1:0]        owner, ownerNext;
    logic [1:0]        lastOwner, lastOwnerNext;
    logic [HOLD_W-1:0] holdCount, holdNext;
    logic [2:0]        grantNext;
    logic [15:0]       addrNext;
    logic              validNext;
    logic              timeoutNext;
    logic [2:0]        winner;
    logic [1:0]        winnerIdx;
    logic [15:0]       ownerAddr;
    logic              ownerDone, ownerReq, holdExpired;
    logic              codeBad, badSeen;

    rr_picker picker (
        .req     (req),
        .pointer (lastOwner),
        .winner  (winner)
    );

    assign winnerIdx   = oneHotToIndex(winner);
    assign ownerDone   = done[owner];
    assign ownerReq    = req[owner];
    assign holdExpired = (holdCount == HOLD_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        case (owner)
            REQ_EXE:  ownerAddr = addrIn0;
            REQ_ALU:  ownerAddr = addrIn1;
            REQ_HOST: ownerAddr = addrIn2;
            default:  ownerAddr = '0;
        endcase
    end

    always_comb begin
        stateNext     = state;
        grantNext     = grant;
        addrNext      = addressBus;
        validNext     = busValid;
        timeoutNext   = 1'b0;
        holdNext      = holdCount;
        ownerNext     = owner;
        lastOwnerNext = lastOwner;
        case (state)
            IDLE: begin
                if (|req) begin
                    stateNext     = OWNED;
                    grantNext     = winner;
                    ownerNext     = winnerIdx;
                    lastOwnerNext = winnerIdx;
                    holdNext      = '0;
                end
            end
            OWNED: begin
                if (ownerDone || !ownerReq || holdExpired) begin
                    stateNext   = GAP;
                    grantNext   = '0;
                    validNext   = 1'b0;
                    addrNext    = '0;
                    // A forced release only counts when the owner was not leaving anyway.
                    timeoutNext = holdExpired && !ownerDone && ownerReq;
                end else begin
                    validNext = 1'b1;
                    addrNext  = ownerAddr;
                    holdNext  = holdCount + 1'b1;
                end
            end
            GAP:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= '0;
            addressBus <= '0;
            busValid   <= 1'b0;
            timeout    <= 1'b0;
            holdCount  <= '0;
            owner      <= REQ_EXE;
            lastOwner  <= REQ_HOST;
            badSeen    <= 1'b0;
        end else begin
            state      <= stateNext;
            grant      <= grantNext;
            addressBus <= addrNext;
            busValid   <= validNext;
            timeout    <= timeoutNext;
            holdCount  <= holdNext;
            owner      <= ownerNext;
            lastOwner  <= lastOwnerNext;
            badSeen    <= busValid && codeBad;
        end
    end

    assign codeBad     = addressBus[15:12] > TGT_REG;
    // Pulse once per run of valid bad addresses rather than holding high.
    assign decodeError = busValid && codeBad && !badSeen;

    always_comb begin
        targetEnable = '0;
        if (busValid) begin
            case (addressBus[15:12])
                TGT_INSTR: targetEnable[0] = 1'b1;
                TGT_MEM:   targetEnable[1] = 1'b1;
                TGT_ALU:   targetEnable[2] = 1'b1;
                TGT_EXE:   targetEnable[3] = 1'b1;
                TGT_REG:   targetEnable[4] = 1'b1;
                default:   targetEnable    = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter with an 8-cycle hold limit.
module tb_bus_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  req, done;
    logic [15:0] addrIn0, addrIn1, addrIn2;
    logic [2:0]  grant;
    logic [15:0] addressBus;
    logic        busValid;
    logic [4:0]  targetEnable;
    logic        decodeError;
    logic        timeout;

    int unsigned passCount  = 0;
    int unsigned checkCount = 0;

    bus_arbiter #(.TIMEOUT_CYCLES(8), .NUM_REQ(3)) dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .done         (done),
        .addrIn0      (addrIn0),
        .addrIn1      (addrIn1),
        .addrIn2      (addrIn2),
        .grant        (grant),
        .addressBus   (addressBus),
        .busValid     (busValid),
        .targetEnable (targetEnable),
        .decodeError  (decodeError),
        .timeout      (timeout)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checkCount++;
        if (grant !== 3'b000) $display("FAIL reset_grant: got %b expected 000", grant);
        else passCount++;
        checkCount++;
        if (busValid !== 1'b0) $display("FAIL reset_busValid: got %b expected 0", busValid);
        else passCount++;
        checkCount++;
        if (addressBus !== 16'h0000) $display("FAIL reset_addressBus: got %h expected 0000", addressBus);
        else passCount++;
        checkCount++;
        if (timeout !== 1'b0 || decodeError !== 1'b0)
            $display("FAIL reset_pulses: got timeout=%b decodeError=%b expected 0 0", timeout, decodeError);
        else passCount++;
        checkCount++;
        if (targetEnable !== 5'b00000) $display("FAIL reset_targetEnable: got %b expected 00000", targetEnable);
        else passCount++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        logic [2:0]  expGrant [3] = '{3'b001, 3'b010, 3'b100};
        logic [15:0] expAddr  [3] = '{16'h1230, 16'h2456, 16'h4abc};
        logic [4:0]  expTe    [3] = '{5'b00010, 5'b00100, 5'b10000};
        addrIn0 = 16'h1230;
        addrIn1 = 16'h2456;
        addrIn2 = 16'h4abc;
        req = 3'b111;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkCount++;
            if (grant !== expGrant[i] || busValid !== 1'b0)
                $display("FAIL rr_grant%0d: got grant=%b busValid=%b expected %b 0", i, grant, busValid, expGrant[i]);
            else passCount++;
            tick();
            checkCount++;
            if (addressBus !== expAddr[i] || busValid !== 1'b1)
                $display("FAIL rr_addr%0d: got %h valid=%b expected %h 1", i, addressBus, busValid, expAddr[i]);
            else passCount++;
            checkCount++;
            if (targetEnable !== expTe[i])
                $display("FAIL rr_target%0d: got %b expected %b", i, targetEnable, expTe[i]);
            else passCount++;
            done = expGrant[i];
            tick();
            done = 3'b000;
            checkCount++;
            if (grant !== 3'b000 || busValid !== 1'b0 || addressBus !== 16'h0000 || timeout !== 1'b0)
                $display("FAIL rr_gap%0d: got grant=%b valid=%b addr=%h timeout=%b expected 000 0 0000 0",
                         i, grant, busValid, addressBus, timeout);
            else passCount++;
            tick();
            checkCount++;
            if (grant !== 3'b000) $display("FAIL rr_idle%0d: got %b expected 000", i, grant);
            else passCount++;
        end
        req = 3'b000;
        tick();
    endtask

    task automatic test_timeout();
        req = 3'b010;
        tick();
        checkCount++;
        if (grant !== 3'b010) $display("FAIL to_grant: got %b expected 010", grant);
        else passCount++;
        for (int c = 2; c <= 8; c++) begin
            tick();
            checkCount++;
            if (grant !== 3'b010 || timeout !== 1'b0)
                $display("FAIL to_hold%0d: got grant=%b timeout=%b expected 010 0", c, grant, timeout);
            else passCount++;
        end
        tick();
        checkCount++;
        if (grant !== 3'b000 || timeout !== 1'b1)
            $display("FAIL to_release: got grant=%b timeout=%b expected 000 1", grant, timeout);
        else passCount++;
        tick();
        checkCount++;
        if (timeout !== 1'b0 || grant !== 3'b000)
            $display("FAIL to_single_pulse: got timeout=%b grant=%b expected 0 000", timeout, grant);
        else passCount++;
        tick();
        checkCount++;
        if (grant !== 3'b010) $display("FAIL to_rearbitrate: got %b expected 010", grant);
        else passCount++;
        req = 3'b000;
        tick();
        checkCount++;
        if (grant !== 3'b000 || timeout !== 1'b0)
            $display("FAIL to_reqdrop: got grant=%b timeout=%b expected 000 0", grant, timeout);
        else passCount++;
        tick();
    endtask

    task automatic test_decode_error();
        addrIn0 = 16'h7000;
        req = 3'b001;
        tick();
        checkCount++;
        if (grant !== 3'b001 || decodeError !== 1'b0)
            $display("FAIL de_grant: got grant=%b decodeError=%b expected 001 0", grant, decodeError);
        else passCount++;
        tick();
        checkCount++;
        if (busValid !== 1'b1 || addressBus !== 16'h7000 || decodeError !== 1'b1)
            $display("FAIL de_pulse: got valid=%b addr=%h decodeError=%b expected 1 7000 1",
                     busValid, addressBus, decodeError);
        else passCount++;
        checkCount++;
        if (targetEnable !== 5'b00000) $display("FAIL de_target: got %b expected 00000", targetEnable);
        else passCount++;
        tick();
        checkCount++;
        if (decodeError !== 1'b0 || busValid !== 1'b1)
            $display("FAIL de_once: got decodeError=%b valid=%b expected 0 1", decodeError, busValid);
        else passCount++;
        req = 3'b000;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_own();
        req = 3'b010;
        tick();
        tick();
        checkCount++;
        if (grant !== 3'b010 || busValid !== 1'b1)
            $display("FAIL rm_owned: got grant=%b valid=%b expected 010 1", grant, busValid);
        else passCount++;
        reset = 1'b1;
        req = 3'b111;
        tick();
        checkCount++;
        if (grant !== 3'b000 || busValid !== 1'b0 || timeout !== 1'b0)
            $display("FAIL rm_drop: got grant=%b valid=%b timeout=%b expected 000 0 0", grant, busValid, timeout);
        else passCount++;
        reset = 1'b0;
        tick();
        checkCount++;
        if (grant !== 3'b001) $display("FAIL rm_regrant: got %b expected 001", grant);
        else passCount++;
        req = 3'b000;
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        addrIn0 = 16'h3abc;
        addrIn1 = 16'h0111;
        req = 3'b001;
        tick();
        checkCount++;
        if (grant !== 3'b001) $display("FAIL bb_grant0: got %b expected 001", grant);
        else passCount++;
        tick();
        checkCount++;
        if (addressBus !== 16'h3abc || targetEnable !== 5'b01000)
            $display("FAIL bb_addr0: got %h te=%b expected 3abc 01000", addressBus, targetEnable);
        else passCount++;
        addrIn1 = 16'h4fff;
        done = 3'b010;
        tick();
        checkCount++;
        if (grant !== 3'b001 || addressBus !== 16'h3abc)
            $display("FAIL bb_nonowner: got grant=%b addr=%h expected 001 3abc", grant, addressBus);
        else passCount++;
        done = 3'b001;
        req = 3'b011;
        tick();
        done = 3'b000;
        checkCount++;
        if (grant !== 3'b000 || busValid !== 1'b0)
            $display("FAIL bb_gap: got grant=%b valid=%b expected 000 0", grant, busValid);
        else passCount++;
        tick();
        checkCount++;
        if (grant !== 3'b000) $display("FAIL bb_idle: got %b expected 000", grant);
        else passCount++;
        tick();
        checkCount++;
        if (grant !== 3'b010) $display("FAIL bb_next: got %b expected 010", grant);
        else passCount++;
        req = 3'b000;
        tick();
        tick();
    endtask

    initial begin
        reset = 1'b1;
        req = '0;
        done = '0;
        addrIn0 = '0;
        addrIn1 = '0;
        addrIn2 = '0;
        test_reset();
        test_round_robin();
        test_timeout();
        test_decode_error();
        test_reset_mid_own();
        test_back_to_back();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: maximum cycles one owner may hold the bus.
REQ-002 Parameter NUM_REQ, default 3, fixed: requesters 0=EXE, 1=ALU, 2=host/loader.
REQ-003 clock  input  1  single rising-edge clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  3  per-requester bus request, level-sensitive.
REQ-006 done  input  3  per-requester release strobe, one cycle.
REQ-007 addrIn0, addrIn1, addrIn2  input  16 each  requester address words; [15:12] target, [11:0] location.
REQ-008 grant  output  3  one-hot ownership; all zero when no owner.
REQ-009 addressBus  output  16  owner's address, registered.
REQ-010 busValid  output  1  addressBus carries a granted address.
REQ-011 targetEnable  output  5  one-hot decode of addressBus[15:12]: bit0 instruction, bit1 memory, bit2 ALU, bit3 EXE, bit4 register.
REQ-012 decodeError  output  1  one-cycle pulse when busValid and addressBus[15:12] > 4.
REQ-013 timeout  output  1  one-cycle pulse when an owner is forcibly released.

Function
REQ-014 FSM states SHALL be IDLE, OWNED and GAP.
REQ-015 IDLE: if any req is set, the arbiter SHALL pick a winner round-robin starting at lastOwner+1 mod 3, assert grant on the next cycle and go to OWNED; otherwise it stays in IDLE.
REQ-016 Grant latency SHALL be exactly 1 cycle from a sampled req in IDLE.
REQ-017 OWNED: each cycle, addressBus SHALL register addrIn of the owner, with busValid=1.
REQ-018 OWNED SHALL go to GAP when done[owner]=1, req[owner]=0, or holdCount reaches TIMEOUT_CYCLES-1, whichever comes first.
REQ-019 holdCount SHALL clear on entry to OWNED and increment each OWNED cycle; its width is $clog2(TIMEOUT_CYCLES).
REQ-020 timeout SHALL pulse only on the timeout exit, and only if neither done[owner] nor the req drop occurs in the same cycle.
REQ-021 GAP SHALL last exactly 1 cycle with grant=0, busValid=0 and addressBus=16'h0000, then go to IDLE.
REQ-022 The round-robin pointer lastOwner SHALL update when a grant is issued.
REQ-023 done or addrIn from non-owners SHALL be ignored.
REQ-024 A requester that keeps req high after release SHALL be re-arbitrated and SHALL lose to any other pending requester.
REQ-025 targetEnable SHALL be all zero whenever busValid=0 or the code is > 4; decode SHALL be combinational from the registered addressBus.
REQ-026 grant SHALL never have more than one bit set.

Reset
REQ-027 Reset SHALL put the FSM in IDLE and clear grant, busValid, addressBus, decodeError, timeout and holdCount.
REQ-028 Reset SHALL set lastOwner=2 so that requester 0 has first priority.
REQ-029 Reset asserted mid-ownership SHALL drop grant on the next edge, with no timeout pulse and no GAP cycle.

Structure
REQ-030 A shared package SHALL hold the target codes (INSTR=0, MEM=1, ALU=2, EXE=3, REG=4), the requester indices and the FSM state enum, for reuse by execution and memory blocks.
REQ-031 The round-robin winner selection SHALL be a sub-module named rr_picker (3-bit req, 2-bit pointer in; one-hot winner out); all other logic stays in bus_arbiter.

Verification
REQ-032 Apply reset, then assert req=3'b111 together: grant SHALL be 001, then 010, then 100 across successive ownerships, with done pulsed after 2 cycles each and a 1-cycle GAP between owners.
REQ-033 Requester 0 owns with addrIn0=16'h1230: one cycle later addressBus=16'h1230, busValid=1 and targetEnable=5'b00010.
REQ-034 Requester 1 holds req and never pulses done, with TIMEOUT_CYCLES=8: after 8 OWNED cycles timeout SHALL pulse once and grant SHALL go to 0.
REQ-035 Owner drives addrIn=16'h7000: decodeError SHALL pulse and targetEnable=0 while busValid=1.
REQ-036 Assert reset during OWNED: on the next edge grant=0 and busValid=0, and the next grant SHALL go to requester 0.
REQ-037 Owner pulses done in the same cycle that another req rises: the arbiter SHALL pass through exactly one GAP cycle before the new grant.
